// File: rtl/isa24_pkg.sv
// Shared definitions for the 24-bit ISA: opcodes, field layout, immediate limits, error codes.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package isa24_pkg;

    localparam int WORD_W = 24;
    localparam int OP_W   = 4;
    localparam int REG_W  = 6;

    // Field positions within a 24-bit word
    localparam int OP_LSB  = 20;
    localparam int RS_LSB  = 14;
    localparam int RT_LSB  = 8;
    localparam int RD_LSB  = 2;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_MUL   = 4'h3;
    localparam logic [3:0] OP_LI    = 4'h4;
    localparam logic [3:0] OP_LOAD  = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_BEQ   = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_LUI   = 4'h9;
    localparam logic [3:0] OP_ORI   = 4'hA;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_OP  = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_NO_ROOM = 2'd3;

    localparam int IMM8_S_MIN  = -128;
    localparam int IMM8_S_MAX  = 127;
    localparam int IMM8_U_MAX  = 255;
    localparam int IMM16_U_MAX = 65535;
    localparam int IMM20_S_MIN = -524288;
    localparam int IMM20_S_MAX = 524287;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT1 = 2'd1,
        ST_EMIT2 = 2'd2
    } enc_state_t;

    // Treat the immediate as two's complement and test lo <= v <= hi
    function automatic logic imm_in_srange(input logic [23:0] v, input int lo, input int hi);
        logic signed [23:0] sv;
        sv = v;
        return (int'(sv) >= lo) && (int'(sv) <= hi);
    endfunction

    // Treat the immediate as unsigned and test v <= hi (negatives become huge and fail)
    function automatic logic imm_in_urange(input logic [23:0] v, input int hi);
        return int'({8'h00, v}) <= hi;
    endfunction

endpackage

// File: rtl/isa24_pack.sv
// Field packer and range checker: symbolic instruction -> one or two 24-bit words plus verdict.
// Latency: combinational.
// Backpressure: none; ports: op/wide/rs/rt/rd/imm in, word/word2/pair/ok/err_code out.
module isa24_pack
    import isa24_pkg::*;
(
    input  logic [3:0]  op,
    input  logic        wide,
    input  logic [5:0]  rs,
    input  logic [5:0]  rt,
    input  logic [5:0]  rd,
    input  logic [23:0] imm,
    output logic [23:0] word,
    output logic [23:0] word2,
    output logic        pair,
    output logic        ok,
    output logic [1:0]  err_code
);

    always_comb begin
        word     = '0;
        word2    = '0;
        pair     = 1'b0;
        ok       = 1'b1;
        err_code = ERR_NONE;
        case (op)
            OP_HALT: word = '0;
            OP_ADD, OP_MUL: word = {op, rs, rt, rd, 2'b00};
            OP_LI: begin
                if (wide) begin
                    // Pseudo-instruction: LUI loads the high byte, ORI merges the low byte
                    pair  = 1'b1;
                    word  = {OP_LUI, 6'd0, rt, imm[15:8]};
                    word2 = {OP_ORI, rt, rt, imm[7:0]};
                    if (!imm_in_urange(imm, IMM16_U_MAX)) begin
                        ok       = 1'b0;
                        err_code = ERR_RANGE;
                    end
                end else begin
                    word = {op, rs, rt, imm[7:0]};
                    if (!imm_in_srange(imm, IMM8_S_MIN, IMM8_S_MAX)) begin
                        ok       = 1'b0;
                        err_code = ERR_RANGE;
                    end
                end
            end
            OP_LOAD, OP_STORE, OP_BEQ: begin
                word = {op, rs, rt, imm[7:0]};
                if (!imm_in_srange(imm, IMM8_S_MIN, IMM8_S_MAX)) begin
                    ok       = 1'b0;
                    err_code = ERR_RANGE;
                end
            end
            OP_LUI, OP_ORI: begin
                word = {op, rs, rt, imm[7:0]};
                if (!imm_in_urange(imm, IMM8_U_MAX)) begin
                    ok       = 1'b0;
                    err_code = ERR_RANGE;
                end
            end
            OP_JMP: begin
                word = {op, imm[19:0]};
                if (!imm_in_srange(imm, IMM20_S_MIN, IMM20_S_MAX)) begin
                    ok       = 1'b0;
                    err_code = ERR_RANGE;
                end
            end
            default: begin
                ok       = 1'b0;
                err_code = ERR_BAD_OP;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder24.sv
// Sequential ISA encoder: accepts symbolic instructions and writes packed words to IMEM at rising addresses.
// Latency: word appears on wr_en/wr_addr/wr_data one cycle after accept; wide LI adds the ORI a cycle later.
// Backpressure: in_ready low while emitting, after HALT, or when IMEM is full (until clear/rst).
// Ports: clk/rst/clear; in_valid/in_ready/in_op/in_wide/in_rs/in_rt/in_rd/in_imm request;
//        wr_en/wr_addr/wr_data IMEM write; count/halted/full/err/err_code status.
module instr_encoder24 #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic              in_wide,
    input  logic [5:0]        in_rs,
    input  logic [5:0]        in_rt,
    input  logic [5:0]        in_rd,
    input  logic [23:0]       in_imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic [ADDR_W:0]   count,
    output logic              halted,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);
    import isa24_pkg::*;

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] BASE_PTR = (ADDR_W+1)'(BASE_ADDR);

    enc_state_t        state, state_nxt;
    // ptr is one bit wider than the address so "one past the last slot" is representable
    logic [ADDR_W:0]   ptr;
    logic              pair_pending;
    logic [23:0]       ori_word;

    logic [23:0]       pk_word, pk_word2;
    logic              pk_pair, pk_ok;
    logic [1:0]        pk_err_code;

    logic              accept, room_ok, good, bad;
    logic [ADDR_W:0]   free_slots;
    logic [1:0]        bad_code;

    isa24_pack u_pack (
        .op       (in_op),
        .wide     (in_wide),
        .rs       (in_rs),
        .rt       (in_rt),
        .rd       (in_rd),
        .imm      (in_imm),
        .word     (pk_word),
        .word2    (pk_word2),
        .pair     (pk_pair),
        .ok       (pk_ok),
        .err_code (pk_err_code)
    );

    assign in_ready   = (state == ST_IDLE) && !halted && !full;
    assign accept     = in_valid && in_ready;
    assign free_slots = CAPACITY - ptr;
    assign room_ok    = !pk_pair || (free_slots >= (ADDR_W+1)'(2));
    assign good       = accept && pk_ok && room_ok;
    assign bad        = accept && !(pk_ok && room_ok);
    // Encoding/range faults outrank the room check
    assign bad_code   = pk_ok ? ERR_NO_ROOM : pk_err_code;
    assign count      = ptr - BASE_PTR;
    assign full       = (ptr == CAPACITY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (good) state_nxt = ST_EMIT1;
                ST_EMIT1: state_nxt = pair_pending ? ST_EMIT2 : ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en        <= 1'b0;
            wr_addr      <= ADDR_W'(BASE_ADDR);
            wr_data      <= '0;
            ptr          <= BASE_PTR;
            pair_pending <= 1'b0;
            ori_word     <= '0;
            halted       <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
        end else if (clear) begin
            wr_en        <= 1'b0;
            wr_addr      <= ADDR_W'(BASE_ADDR);
            wr_data      <= '0;
            ptr          <= BASE_PTR;
            pair_pending <= 1'b0;
            ori_word     <= '0;
            halted       <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
        end else begin
            wr_en <= 1'b0;
            if (good) begin
                wr_en        <= 1'b1;
                wr_data      <= pk_word;
                wr_addr      <= ptr[ADDR_W-1:0];
                ptr          <= ptr + 1'b1;
                pair_pending <= pk_pair;
                ori_word     <= pk_word2;
                if (in_op == OP_HALT) halted <= 1'b1;
            end else if (bad) begin
                err <= 1'b1;
                if (!err) err_code <= bad_code;
            end
            // Second half of the wide LI, at the next consecutive address
            if (state == ST_EMIT1 && pair_pending) begin
                wr_en        <= 1'b1;
                wr_data      <= ori_word;
                wr_addr      <= ptr[ADDR_W-1:0];
                ptr          <= ptr + 1'b1;
                pair_pending <= 1'b0;
            end
        end
    end

endmodule
